// File: rtl/clint_timer.sv
// CLINT machine timer and software-interrupt block.
// Exposes msip, mtimecmp and mtime behind a one-outstanding valid/ready bus.
module clint_timer #(
    parameter logic [63:0] BASE     = 64'h0200_0000,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_write,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_strobe,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        trint,
    output logic        swint
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [15:0] DIV_M1 = 16'(TICK_DIV - 1);
    localparam logic [63:0] A_MSIP = BASE;
    localparam logic [63:0] A_CMP  = BASE + 64'h4000;
    localparam logic [63:0] A_TIME = BASE + 64'hBFF8;

    state_t      state_q, state_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [63:0] rdata_q, rdata_d;
    logic [15:0] presc_q, presc_d;
    logic        msip_q, msip_d;
    logic        err_q, err_d;

    logic        aligned;
    logic        hit_msip, hit_cmp, hit_time, bad;
    logic        tick;
    logic [63:0] mtime_inc;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign trint      = (mtime_q >= mtimecmp_q);
    assign swint      = msip_q;

    always_comb begin
        aligned  = (req_addr[2:0] == 3'b000);
        hit_msip = aligned && (req_addr == A_MSIP);
        hit_cmp  = aligned && (req_addr == A_CMP);
        hit_time = aligned && (req_addr == A_TIME);
        bad      = !(hit_msip || hit_cmp || hit_time);
        tick     = (presc_q == DIV_M1);
        presc_d  = tick ? 16'd0 : presc_q + 16'd1;
        // written mtime bytes override the ticked value byte by byte
        mtime_inc  = mtime_q + {63'd0, tick};
        state_d    = state_q;
        mtime_d    = mtime_inc;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = RESP;
                    err_d   = bad;
                    rdata_d = '0;
                    if (!req_write) begin
                        unique case (1'b1)
                            hit_msip: rdata_d = {63'd0, msip_q};
                            hit_cmp:  rdata_d = mtimecmp_q;
                            hit_time: rdata_d = mtime_q;
                            default:  rdata_d = '0;
                        endcase
                    end else if (!bad) begin
                        for (int b = 0; b < 8; b++) begin
                            if (req_strobe[b] && hit_cmp)
                                mtimecmp_d[8*b +: 8] = req_wdata[8*b +: 8];
                            if (req_strobe[b] && hit_time)
                                mtime_d[8*b +: 8] = req_wdata[8*b +: 8];
                        end
                        if (hit_msip && req_strobe[0])
                            msip_d = req_wdata[0];
                    end
                end
            end
            RESP: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            rdata_q    <= '0;
            presc_q    <= '0;
            msip_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            rdata_q    <= rdata_d;
            presc_q    <= presc_d;
            msip_q     <= msip_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_clint_timer.sv
// Scoreboard bench for clint_timer: two instances (TICK_DIV 1 and 4)
// share one bus stimulus and are checked against a behavioural model.
module tb_clint_timer;

    localparam logic [63:0] BASE   = 64'h0200_0000;
    localparam logic [63:0] A_MSIP = BASE;
    localparam logic [63:0] A_CMP  = BASE + 64'h4000;
    localparam logic [63:0] A_TIME = BASE + 64'hBFF8;

    typedef struct {
        logic [63:0] rd;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [63:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_strobe = '0;
    logic        resp_ready = 1'b0;

    logic        req_ready_w  [2];
    logic        resp_valid_w [2];
    logic [63:0] resp_rdata_w [2];
    logic        resp_err_w   [2];
    logic        trint_w      [2];
    logic        swint_w      [2];

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp   [2];
    logic        m_msip  [2];
    int          m_pre   [2];
    bit          m_busy  [2];
    exp_t        exp_q0 [$];
    exp_t        exp_q1 [$];

    always #5 clk = ~clk;

    clint_timer #(.BASE(BASE), .TICK_DIV(1)) u_div1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_w[0]),
        .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_strobe(req_strobe),
        .resp_valid(resp_valid_w[0]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_w[0]), .resp_err(resp_err_w[0]),
        .trint(trint_w[0]), .swint(swint_w[0])
    );

    clint_timer #(.BASE(BASE), .TICK_DIV(4)) u_div4 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready_w[1]),
        .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_strobe(req_strobe),
        .resp_valid(resp_valid_w[1]), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_w[1]), .resp_err(resp_err_w[1]),
        .trint(trint_w[1]), .swint(swint_w[1])
    );

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    task automatic chk(input string nm, input int i,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t act=%h exp=%h",
                     nm, i, $time, act, exp);
        end
    endtask

    // Reference: applies the register-map rules once per clock edge.
    task automatic model_step(input int i);
        logic [63:0] nt, ncmp, off;
        logic        nmsip, err, tick;
        exp_t        e;
        if (reset) begin
            m_mtime[i] = '0;
            m_cmp[i]   = '1;
            m_msip[i]  = 1'b0;
            m_pre[i]   = 0;
            m_busy[i]  = 1'b0;
            if (i == 0) exp_q0.delete();
            else        exp_q1.delete();
            return;
        end
        tick  = (m_pre[i] == div_of(i) - 1);
        nt    = m_mtime[i] + (tick ? 64'd1 : 64'd0);
        ncmp  = m_cmp[i];
        nmsip = m_msip[i];
        m_pre[i] = tick ? 0 : m_pre[i] + 1;
        if (m_busy[i]) begin
            if (resp_ready) m_busy[i] = 1'b0;
        end else if (req_valid) begin
            m_busy[i] = 1'b1;
            off = req_addr - BASE;
            err = (req_addr[2:0] != 3'b0) ||
                  !(off == 64'h0 || off == 64'h4000 || off == 64'hBFF8);
            e.err = err;
            e.rd  = '0;
            if (!err && !req_write) begin
                if (off == 64'h0)         e.rd = {63'd0, m_msip[i]};
                else if (off == 64'h4000) e.rd = m_cmp[i];
                else                      e.rd = m_mtime[i];
            end
            if (!err && req_write) begin
                for (int b = 0; b < 8; b++) begin
                    if (req_strobe[b]) begin
                        if (off == 64'h4000) ncmp[8*b +: 8] = req_wdata[8*b +: 8];
                        if (off == 64'hBFF8) nt[8*b +: 8]   = req_wdata[8*b +: 8];
                    end
                end
                if (off == 64'h0 && req_strobe[0]) nmsip = req_wdata[0];
            end
            if (i == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
        m_mtime[i] = nt;
        m_cmp[i]   = ncmp;
        m_msip[i]  = nmsip;
    endtask

    initial begin : model
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    initial begin : monitor
        exp_t e;
        bit   have;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 2; i++) begin
                    chk("resp_valid", i, {63'd0, resp_valid_w[i]}, {63'd0, m_busy[i]});
                    chk("req_ready", i, {63'd0, req_ready_w[i]}, {63'd0, !m_busy[i]});
                    chk("trint", i, {63'd0, trint_w[i]},
                        {63'd0, (m_mtime[i] >= m_cmp[i])});
                    chk("swint", i, {63'd0, swint_w[i]}, {63'd0, m_msip[i]});
                    if (resp_valid_w[i]) begin
                        have = (i == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
                        if (!have) begin
                            chk("resp_unexpected", i, 64'd1, 64'd0);
                        end else begin
                            e = (i == 0) ? exp_q0[0] : exp_q1[0];
                            chk("resp_rdata", i, resp_rdata_w[i], e.rd);
                            chk("resp_err", i, {63'd0, resp_err_w[i]}, {63'd0, e.err});
                            if (resp_ready) begin
                                if (i == 0) void'(exp_q0.pop_front());
                                else        void'(exp_q1.pop_front());
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    // One transaction; while the response is held, junk requests are driven
    // that must not be accepted.
    task automatic xact(input logic [63:0] a, input logic w,
                        input logic [63:0] d, input logic [7:0] s,
                        input int hold, input bit junk);
        req_valid  = 1'b1;
        req_addr   = a;
        req_write  = w;
        req_wdata  = d;
        req_strobe = s;
        resp_ready = 1'b0;
        idle(1);
        req_valid = 1'b0;
        repeat (hold) begin
            if (junk) begin
                req_valid  = 1'($urandom_range(0, 1));
                req_addr   = A_TIME;
                req_write  = 1'b1;
                req_wdata  = {$urandom, $urandom};
                req_strobe = 8'hFF;
            end
            idle(1);
        end
        resp_ready = 1'b1;
        idle(1);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
    endtask

    function automatic logic [63:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return A_MSIP;
        if (r < 5) return A_CMP;
        if (r < 8) return A_TIME;
        if (r == 8) return BASE + 64'(8 * $urandom_range(1, 8));
        return A_CMP + 64'($urandom_range(1, 7));
    endfunction

    initial begin : stim
        logic [63:0] a, d;
        logic [7:0]  s;
        do_reset();
        chk_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_rdata", i, resp_rdata_w[i], 64'd0);
            chk("reset_err", i, {63'd0, resp_err_w[i]}, 64'd0);
            chk("reset_trint", i, {63'd0, trint_w[i]}, 64'd0);
        end

        idle(10);
        xact(A_TIME, 1'b0, '0, 8'h00, 0, 1'b0);

        xact(A_CMP, 1'b1, 64'd20, 8'hFF, 0, 1'b0);
        xact(A_TIME, 1'b1, 64'd5, 8'hFF, 0, 1'b0);
        idle(20);
        xact(A_CMP, 1'b1, 64'd100, 8'hFF, 0, 1'b0);
        idle(2);

        xact(A_MSIP, 1'b1, 64'd1, 8'hFF, 0, 1'b0);
        xact(A_MSIP, 1'b1, 64'd0, 8'hFF, 0, 1'b0);
        xact(A_MSIP, 1'b1, 64'hFFFF, 8'hFF, 1, 1'b0);
        xact(A_MSIP, 1'b0, '0, 8'h00, 0, 1'b0);
        xact(A_MSIP, 1'b1, 64'h0, 8'h00, 0, 1'b0);

        xact(A_CMP, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 1'b0);
        xact(A_TIME, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 0, 1'b0);
        idle(6);

        xact(BASE + 64'h8, 1'b0, '0, 8'h00, 0, 1'b0);
        xact(BASE + 64'h4004, 1'b0, '0, 8'h00, 3, 1'b1);
        xact(BASE + 64'h4004, 1'b1, '1, 8'hFF, 2, 1'b1);

        for (int g = 0; g < 4; g++) begin
            idle(g);
            xact(A_TIME, 1'b1, 64'h0000_0000_0000_12FF, 8'hFF, 0, 1'b0);
            xact(A_TIME, 1'b1, 64'h0, 8'h01, 0, 1'b0);
            xact(A_TIME, 1'b0, '0, 8'h00, 0, 1'b0);
        end

        xact(A_MSIP, 1'b1, 64'd1, 8'h01, 0, 1'b0);
        req_valid = 1'b1;
        req_addr  = A_CMP;
        req_write = 1'b0;
        idle(1);
        req_valid = 1'b0;
        idle(1);
        do_reset();
        idle(2);

        for (int n = 0; n < 250; n++) begin
            a = rand_addr();
            s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            case ($urandom_range(0, 3))
                0: d = {$urandom, $urandom};
                1: d = m_mtime[0] + 64'($urandom_range(0, 40));
                2: d = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
                default: d = 64'($urandom_range(0, 200));
            endcase
            xact(a, 1'($urandom_range(0, 1)), d, s,
                 $urandom_range(0, 3), 1'b1);
            idle($urandom_range(0, 3));
        end

        idle(3);
        chk("drain0", 0, 64'(exp_q0.size()), 64'd0);
        chk("drain1", 1, 64'(exp_q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clint_timer.md
CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 Parameter BASE, default 64'h0200_0000; base address of the register window.
REQ-002 Parameter TICK_DIV, default 1; clk cycles per mtime increment, legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 req_valid  input  1  bus request present.
REQ-006 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-007 req_addr  input  64  byte address of the request.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_wdata  input  64  write data.
REQ-010 req_strobe  input  8  byte enables for writes; ignored on reads.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  response consumed when resp_valid && resp_ready.
REQ-013 resp_rdata  output  64  read data; 0 for writes and errors.
REQ-014 resp_err  output  1  access fault (unmapped or misaligned).
REQ-015 trint  output  1  machine timer interrupt pending, feeds mip.MTIP.
REQ-016 swint  output  1  machine software interrupt pending, feeds mip.MSIP.

Function
REQ-017 Register map: msip at BASE+0x0000 (bit 0 only; other bits read 0); mtimecmp at BASE+0x4000 (64 bits); mtime at BASE+0xBFF8 (64 bits).
REQ-018 Bus FSM has two states, IDLE and RESP; req_ready = (state == IDLE); resp_valid = (state == RESP).
REQ-019 IDLE -> RESP on accepted request; RESP -> IDLE on resp_ready; one outstanding request, no request accepted in RESP.
REQ-020 Response appears the cycle after acceptance (latency 1); resp_rdata/resp_err are held stable while resp_valid && !resp_ready.
REQ-021 Read data is the register value at the acceptance edge, before any same-cycle increment.
REQ-022 Writes commit at the acceptance edge, byte-wise per req_strobe; unstrobed bytes unchanged; strobe 0 is a legal no-op with resp_err = 0.
REQ-023 Address outside the three registers, or req_addr[2:0] != 0 -> resp_err = 1, resp_rdata = 0, no state change.
REQ-024 Prescaler counts 0..TICK_DIV-1; mtime increments by 1 on the cycle the prescaler wraps; TICK_DIV = 1 -> increment every cycle.
REQ-025 mtime wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
REQ-026 mtime write and tick on the same edge: written bytes take write data, unwritten bytes take the incremented value; prescaler clears to 0.
REQ-027 trint = (mtime >= mtimecmp), unsigned 64-bit compare on current register values, combinational from registers.
REQ-028 swint = msip[0], driven from the register.
REQ-029 A write to mtimecmp takes effect on trint the cycle after acceptance; trint deasserts only by raising mtimecmp or by mtime wrapping.

Reset
REQ-030 On reset: state = IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-031 On reset: mtime = 0, prescaler = 0, msip = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; therefore trint = 0 and swint = 0.
REQ-032 Reset asserted in RESP drops the pending response without a handshake; reset has priority over all writes and ticks.

Verification
REQ-033 Reset, TICK_DIV = 1, idle 10 cycles, read mtime -> resp_rdata = 10 (±1 for the acceptance edge, checked exactly against the model), resp_err = 0.
REQ-034 Write mtimecmp = 20 with strobe 8'hFF, mtime = 5 -> trint rises on the cycle mtime reaches 20; write mtimecmp = 100 -> trint = 0 the next cycle.
REQ-035 Write msip = 1 -> swint = 1 one cycle after acceptance; write msip = 0 -> swint = 0; read msip after writing 64'hFFFF -> resp_rdata = 1.
REQ-036 Write mtime = 64'hFFFF_FFFF_FFFF_FFFE with mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF -> trint = 1 for one cycle, then mtime = 0 and trint = 0.
REQ-037 Read BASE+0x8, then read BASE+0x4004 -> resp_err = 1, resp_rdata = 0, no register changes; hold resp_ready = 0 for 3 cycles -> response stable and req_ready = 0.
REQ-038 TICK_DIV = 4, write mtime[7:0] = 8'h00 (strobe 8'h01) on a tick edge -> byte 0 = 0, upper bytes incremented, next increment occurs 4 cycles later.
